// File: rtl/ps2_scan_receiver.sv
// PS/2 device-to-host receiver: pin synchroniser, frame deframer, E0/F0 prefix folding
// and a first-word-fall-through scan-code queue.
module ps2_scan_receiver #(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned TIMEOUT_CYC = 20000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       code_ready,
    output logic       code_valid,
    output logic [7:0] scan_code,
    output logic       is_break,
    output logic       is_ext,
    output logic       overflow,
    output logic       frame_err,
    output logic [7:0] press_cnt
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned EW = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t          state, state_next;
    logic            clk_s1, clk_s2, clk_hist;
    logic            dat_s1, dat_s2;
    logic            fall;
    logic [3:0]      bit_cnt;
    logic [10:0]     shreg;
    logic [TW-1:0]   tmr;
    logic            ext_flag, brk_flag;

    logic            shift_en, cnt_clr, tmr_clr;
    logic            push_req, set_ext, set_brk, clr_flags, err_c;
    logic            frame_ok;
    logic [7:0]      rx_byte;

    logic [EW-1:0]   mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            full, pop, wr_ok;
    logic [EW-1:0]   head;

    // Two-flop synchronisers plus a history flop on ps2_clk; idle line is high
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_hist <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
        end else begin
            clk_s1   <= ps2_clk;
            clk_s2   <= clk_s1;
            clk_hist <= clk_s2;
            dat_s1   <= ps2_data;
            dat_s2   <= dat_s1;
        end
    end

    assign fall     = clk_hist & ~clk_s2;
    assign rx_byte  = shreg[8:1];
    assign frame_ok = ~shreg[0] & (^shreg[9:1]) & shreg[10];

    // FSM state register
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state and datapath control
    always_comb begin
        state_next = state;
        shift_en   = 1'b0;
        cnt_clr    = 1'b0;
        tmr_clr    = 1'b0;
        push_req   = 1'b0;
        set_ext    = 1'b0;
        set_brk    = 1'b0;
        clr_flags  = 1'b0;
        err_c      = 1'b0;
        case (state)
            IDLE: begin
                if (fall && !dat_s2) begin
                    state_next = RECV;
                    shift_en   = 1'b1;
                    cnt_clr    = 1'b1;
                    tmr_clr    = 1'b1;
                end
            end
            RECV: begin
                if (fall) begin
                    shift_en = 1'b1;
                    tmr_clr  = 1'b1;
                    if (bit_cnt == 4'd10) state_next = CHECK;
                end else if (tmr == TW'(TIMEOUT_CYC - 1)) begin
                    state_next = IDLE;
                    err_c      = 1'b1;
                    clr_flags  = 1'b1;
                end
            end
            CHECK: begin
                state_next = IDLE;
                if (frame_ok) begin
                    if (rx_byte == 8'hE0) begin
                        set_ext = 1'b1;
                    end else if (rx_byte == 8'hF0) begin
                        set_brk = 1'b1;
                    end else begin
                        push_req  = 1'b1;
                        clr_flags = 1'b1;
                    end
                end else begin
                    err_c     = 1'b1;
                    clr_flags = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Shift register, bit counter, inactivity timer, prefix flags and error pulse
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            shreg     <= '0;
            bit_cnt   <= '0;
            tmr       <= '0;
            ext_flag  <= 1'b0;
            brk_flag  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (shift_en) shreg <= {dat_s2, shreg[10:1]};
            if (cnt_clr)       bit_cnt <= 4'd1;
            else if (shift_en) bit_cnt <= bit_cnt + 4'd1;
            if (tmr_clr)             tmr <= '0;
            else if (state == RECV)  tmr <= tmr + TW'(1);
            if (clr_flags) begin
                ext_flag <= 1'b0;
                brk_flag <= 1'b0;
            end else begin
                if (set_ext) ext_flag <= 1'b1;
                if (set_brk) brk_flag <= 1'b1;
            end
            frame_err <= err_c;
        end
    end

    assign code_valid = (count != '0);
    assign full       = (count == CW'(FIFO_DEPTH));
    assign pop        = code_valid & code_ready;
    assign wr_ok      = push_req & (~full | pop);

    // Queue storage, pointers, occupancy, sticky overflow and make-code counter
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            press_cnt <= '0;
        end else begin
            if (wr_ok) begin
                mem[wr_ptr] <= {ext_flag, brk_flag, rx_byte};
                wr_ptr      <= wr_ptr + PW'(1);
                if (!brk_flag) press_cnt <= press_cnt + 8'd1;
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            if (wr_ok && !pop)      count <= count + CW'(1);
            else if (!wr_ok && pop) count <= count - CW'(1);
            if (push_req && full && !pop) overflow <= 1'b1;
        end
    end

    // When empty, the slot behind the read pointer is the last head that was shown
    assign head = code_valid ? mem[rd_ptr] : mem[rd_ptr - PW'(1)];
    assign {is_ext, is_break, scan_code} = head;

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Self-checking bench for ps2_scan_receiver with a queue-based reference model.
module tb_ps2_scan_receiver;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned TMO   = 300;
    localparam int          H     = 6;

    logic       clk = 1'b0;
    logic       clrn, ps2_clk, ps2_data, code_ready;
    logic       code_valid, is_break, is_ext, overflow, frame_err;
    logic [7:0] scan_code, press_cnt;

    ps2_scan_receiver #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .code_ready(code_ready), .code_valid(code_valid), .scan_code(scan_code),
        .is_break(is_break), .is_ext(is_ext), .overflow(overflow),
        .frame_err(frame_err), .press_cnt(press_cnt)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [9:0] obs[$];
    logic [9:0] exp_q[$];
    int         ck_idx     = 0;
    int         err_cycles = 0;
    int         exp_err    = 0;
    logic       m_ext = 0, m_brk = 0, m_ovf = 0, m_hold = 0;
    int         m_occ = 0;
    logic [7:0] m_press = 0;

    // Record every accepted entry and every cycle frame_err is high
    always @(negedge clk) begin
        if (clrn && code_valid && code_ready) obs.push_back({is_ext, is_break, scan_code});
        if (frame_err) err_cycles++;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        return {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    endfunction

    // Drive the first n bits of a frame; returns right after the last falling edge
    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1 ps2_clk = 1'b1; ps2_data = f[i];
            repeat (H) @(posedge clk);
            #1 ps2_clk = 1'b0;
            if (i != n - 1) repeat (H - 1) @(posedge clk);
        end
    endtask

    // Reference behaviour for one received byte
    task automatic model_byte(input logic [7:0] b, input bit good);
        if (!good) begin
            m_ext = 0; m_brk = 0; exp_err++;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else begin
            if (m_hold && m_occ >= int'(DEPTH)) begin
                m_ovf = 1;
            end else begin
                exp_q.push_back({m_ext, m_brk, b});
                if (m_hold) m_occ++;
                if (!m_brk) m_press++;
            end
            m_ext = 0; m_brk = 0;
        end
    endtask

    task automatic send_code(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        send_bits(mk_frame(b, bad_par, bad_stop), 11);
        model_byte(b, !(bad_par || bad_stop));
    endtask

    task automatic settle();
        repeat (12) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        code_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (!code_valid) break;
        end
        n_checks++;
        if (code_valid !== 1'b0) begin n_fail++; $display("FAIL drain_timeout: code_valid=%b want 0", code_valid); end
        m_occ = 0; m_hold = 0;
        settle();
    endtask

    task automatic test_reset();
        clrn = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; code_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({code_valid, scan_code, is_break, is_ext, overflow, frame_err, press_cnt} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got cv=%b sc=%h brk=%b ext=%b ovf=%b err=%b cnt=%0d want all 0",
                     code_valid, scan_code, is_break, is_ext, overflow, frame_err, press_cnt);
        end
        clrn = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_single_make();
        code_ready = 1'b1;
        send_code(8'h1C, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (code_valid !== 1'b0) begin n_fail++; $display("FAIL t1_early: code_valid=%b want 0", code_valid); end
        @(posedge clk); #1;
        n_checks++;
        if ({code_valid, is_ext, is_break, scan_code} !== {1'b1, exp_q[ck_idx]}) begin
            n_fail++;
            $display("FAIL t1_entry: got cv=%b ext=%b brk=%b sc=%h want 1 %h",
                     code_valid, is_ext, is_break, scan_code, exp_q[ck_idx]);
        end
        n_checks++;
        if (press_cnt !== m_press) begin n_fail++; $display("FAIL t1_press: got %0d want %0d", press_cnt, m_press); end
        @(posedge clk); #1;
        n_checks++;
        if ({code_valid, scan_code} !== {1'b0, 8'h1C}) begin
            n_fail++; $display("FAIL t1_hold: got cv=%b sc=%h want 0 1c", code_valid, scan_code);
        end
        settle();
        n_checks++;
        if (obs.size() !== exp_q.size()) begin n_fail++; $display("FAIL t1_count: got %0d want %0d", obs.size(), exp_q.size()); end
        ck_idx = exp_q.size();
    endtask

    task automatic test_prefixes();
        send_code(8'hF0, 0, 0); send_code(8'h1C, 0, 0);
        send_code(8'hE0, 0, 0); send_code(8'hF0, 0, 0); send_code(8'h75, 0, 0);
        settle();
        n_checks++;
        if (obs.size() !== exp_q.size()) begin n_fail++; $display("FAIL t2_count: got %0d want %0d", obs.size(), exp_q.size()); end
        for (int i = ck_idx; i < exp_q.size() && i < obs.size(); i++) begin
            n_checks++;
            if (obs[i] !== exp_q[i]) begin n_fail++; $display("FAIL t2_entry[%0d]: got %h want %h", i, obs[i], exp_q[i]); end
        end
        ck_idx = exp_q.size();
        n_checks++;
        if (press_cnt !== m_press) begin n_fail++; $display("FAIL t2_press: got %0d want %0d", press_cnt, m_press); end
    endtask

    task automatic test_bad_parity();
        send_code(8'hE0, 0, 0);
        send_code(8'h16, 1, 0);
        settle();
        n_checks++;
        if (err_cycles !== exp_err) begin n_fail++; $display("FAIL t3_err: got %0d want %0d", err_cycles, exp_err); end
        n_checks++;
        if (obs.size() !== exp_q.size()) begin n_fail++; $display("FAIL t3_noentry: got %0d want %0d", obs.size(), exp_q.size()); end
        send_code(8'h16, 0, 0);
        settle();
        for (int i = ck_idx; i < exp_q.size() && i < obs.size(); i++) begin
            n_checks++;
            if (obs[i] !== exp_q[i]) begin n_fail++; $display("FAIL t3_entry[%0d]: got %h want %h", i, obs[i], exp_q[i]); end
        end
        n_checks++;
        if (obs.size() !== exp_q.size()) begin n_fail++; $display("FAIL t3_count: got %0d want %0d", obs.size(), exp_q.size()); end
        ck_idx = exp_q.size();
    endtask

    task automatic test_timeout();
        send_bits(mk_frame(8'h33, 0, 0), 6);
        m_ext = 0; m_brk = 0; exp_err++;
        repeat (TMO + 10) @(posedge clk);
        #1;
        n_checks++;
        if (err_cycles !== exp_err) begin n_fail++; $display("FAIL t5_err: got %0d want %0d", err_cycles, exp_err); end
        send_code(8'h45, 0, 0);
        settle();
        n_checks++;
        if (obs.size() !== exp_q.size()) begin n_fail++; $display("FAIL t5_count: got %0d want %0d", obs.size(), exp_q.size()); end
        for (int i = ck_idx; i < exp_q.size() && i < obs.size(); i++) begin
            n_checks++;
            if (obs[i] !== exp_q[i]) begin n_fail++; $display("FAIL t5_entry[%0d]: got %h want %h", i, obs[i], exp_q[i]); end
        end
        ck_idx = exp_q.size();
    endtask

    task automatic test_full_with_pop();
        code_ready = 1'b0; m_hold = 1;
        for (int i = 0; i < int'(DEPTH); i++) send_code(8'h20 + 8'(i), 0, 0);
        settle();
        n_checks++;
        if ({code_valid, is_ext, is_break, scan_code} !== {1'b1, exp_q[ck_idx]}) begin
            n_fail++; $display("FAIL fp_head: got %b %h want 1 %h", code_valid, {is_ext, is_break, scan_code}, exp_q[ck_idx]);
        end
        send_bits(mk_frame(8'h28, 0, 0), 11);
        m_occ--;
        model_byte(8'h28, 1);
        repeat (3) @(posedge clk);
        #1 code_ready = 1'b1;
        @(posedge clk);
        #1 code_ready = 1'b0;
        settle();
        n_checks++;
        if (overflow !== m_ovf) begin n_fail++; $display("FAIL fp_overflow: got %b want %b", overflow, m_ovf); end
        n_checks++;
        if ({is_ext, is_break, scan_code} !== exp_q[ck_idx + 1]) begin
            n_fail++; $display("FAIL fp_head2: got %h want %h", {is_ext, is_break, scan_code}, exp_q[ck_idx + 1]);
        end
        drain();
        n_checks++;
        if (obs.size() !== exp_q.size()) begin n_fail++; $display("FAIL fp_count: got %0d want %0d", obs.size(), exp_q.size()); end
        for (int i = ck_idx; i < exp_q.size() && i < obs.size(); i++) begin
            n_checks++;
            if (obs[i] !== exp_q[i]) begin n_fail++; $display("FAIL fp_entry[%0d]: got %h want %h", i, obs[i], exp_q[i]); end
        end
        ck_idx = exp_q.size();
        n_checks++;
        if (press_cnt !== m_press) begin n_fail++; $display("FAIL fp_press: got %0d want %0d", press_cnt, m_press); end
    endtask

    task automatic test_overflow();
        logic [7:0] base_press;
        base_press = m_press;
        code_ready = 1'b0; m_hold = 1;
        for (int i = 0; i <= int'(DEPTH); i++) send_code(8'h15 + 8'(i), 0, 0);
        settle();
        n_checks++;
        if ({code_valid, overflow} !== {1'b1, m_ovf}) begin
            n_fail++; $display("FAIL t4_flags: got cv=%b ovf=%b want 1 %b", code_valid, overflow, m_ovf);
        end
        n_checks++;
        if (press_cnt !== m_press || m_press !== base_press + 8'(DEPTH)) begin
            n_fail++; $display("FAIL t4_press: got %0d want %0d", press_cnt, base_press + 8'(DEPTH));
        end
        n_checks++;
        if ({is_ext, is_break, scan_code} !== exp_q[ck_idx]) begin
            n_fail++; $display("FAIL t4_head: got %h want %h", {is_ext, is_break, scan_code}, exp_q[ck_idx]);
        end
        drain();
        n_checks++;
        if (obs.size() !== exp_q.size()) begin n_fail++; $display("FAIL t4_count: got %0d want %0d", obs.size(), exp_q.size()); end
        for (int i = ck_idx; i < exp_q.size() && i < obs.size(); i++) begin
            n_checks++;
            if (obs[i] !== exp_q[i]) begin n_fail++; $display("FAIL t4_entry[%0d]: got %h want %h", i, obs[i], exp_q[i]); end
        end
        ck_idx = exp_q.size();
    endtask

    task automatic test_reset_midframe();
        code_ready = 1'b0; m_hold = 1;
        send_code(8'h30, 0, 0); send_code(8'h31, 0, 0); send_code(8'h32, 0, 0);
        send_bits(mk_frame(8'h33, 0, 0), 4);
        repeat (4) @(posedge clk);
        #2 clrn = 1'b0;
        #1;
        n_checks++;
        if ({code_valid, overflow, press_cnt} !== 10'd0) begin
            n_fail++; $display("FAIL t6_reset: got cv=%b ovf=%b cnt=%0d want 0 0 0", code_valid, overflow, press_cnt);
        end
        repeat (3) void'(exp_q.pop_back());
        m_press = 0; m_ext = 0; m_brk = 0; m_ovf = 0; m_occ = 0; m_hold = 0;
        ps2_clk = 1'b1; ps2_data = 1'b1;
        repeat (4) @(posedge clk);
        #1 clrn = 1'b1;
        code_ready = 1'b1;
        send_code(8'h1E, 0, 0);
        settle();
        n_checks++;
        if (obs.size() !== exp_q.size()) begin n_fail++; $display("FAIL t6_count: got %0d want %0d", obs.size(), exp_q.size()); end
        for (int i = ck_idx; i < exp_q.size() && i < obs.size(); i++) begin
            n_checks++;
            if (obs[i] !== exp_q[i]) begin n_fail++; $display("FAIL t6_entry[%0d]: got %h want %h", i, obs[i], exp_q[i]); end
        end
        ck_idx = exp_q.size();
        n_checks++;
        if (press_cnt !== m_press) begin n_fail++; $display("FAIL t6_press: got %0d want %0d", press_cnt, m_press); end
    endtask

    task automatic test_random();
        logic [7:0] b;
        code_ready = 1'b1;
        for (int k = 0; k < 25; k++) begin
            do b = 8'($urandom); while (b == 8'hE0 || b == 8'hF0);
            if ($urandom_range(1, 0) == 1) send_code(8'hE0, ($urandom_range(9, 0) == 0), 0);
            if ($urandom_range(1, 0) == 1) send_code(8'hF0, 0, ($urandom_range(9, 0) == 0));
            send_code(b, ($urandom_range(7, 0) == 0), ($urandom_range(11, 0) == 0));
        end
        settle();
        n_checks++;
        if (obs.size() !== exp_q.size()) begin n_fail++; $display("FAIL rnd_count: got %0d want %0d", obs.size(), exp_q.size()); end
        for (int i = ck_idx; i < exp_q.size() && i < obs.size(); i++) begin
            n_checks++;
            if (obs[i] !== exp_q[i]) begin n_fail++; $display("FAIL rnd_entry[%0d]: got %h want %h", i, obs[i], exp_q[i]); end
        end
        ck_idx = exp_q.size();
        n_checks++;
        if (err_cycles !== exp_err) begin n_fail++; $display("FAIL rnd_err: got %0d want %0d", err_cycles, exp_err); end
        n_checks++;
        if ({press_cnt, overflow} !== {m_press, m_ovf}) begin
            n_fail++; $display("FAIL rnd_press: got cnt=%0d ovf=%b want %0d %b", press_cnt, overflow, m_press, m_ovf);
        end
    endtask

    initial begin
        test_reset();
        test_single_make();
        test_prefixes();
        test_bad_parity();
        test_timeout();
        test_full_with_pop();
        test_overflow();
        test_reset_midframe();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
